serial_demux_rx: RTL and testbench

- Parametrised serial frame receiver and demultiplexer, the next generation of the single-channel serial-in controller.
- Detects a start bit, then shifts in a channel address and a length field. Routes the following LEN data bits to one of 2**ADDR_W output channels, then checks an optional parity bit.
- Sits between the board serial input pin and the per-channel consumers.
- Adds features the earlier generation lacks: a channel enable mask, zero-length frames, parity checking and a drop indication.

---
 rtl/serial_demux_rx_pkg.sv | 28 ++
 rtl/serial_field_shifter.sv | 43 ++++
 rtl/serial_demux_rx.sv | 157 +++++++++++++++
 tb/tb_serial_demux_rx.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/serial_demux_rx_pkg.sv
// Shared types and elaboration helpers for the serial frame receiver/demultiplexer.
package serial_demux_rx_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        LEN  = 3'd2,
        DATA = 3'd3,
        PAR  = 3'd4
    } state_t;

    function automatic int nch_of(input int addr_w);
        return int'(32'd1 << addr_w);
    endfunction

    // Smallest counter width (at least 1) able to hold 0..n-1.
    function automatic int cnt_w(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if (int'(32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_field_shifter.sv
// MSB-first serial field collector: shift register, bit counter and a flag
// marking the edge on which the final bit of the field is taken.
module serial_field_shifter
    import serial_demux_rx_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clkEn,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         din,
    output logic [W-1:0] data,
    output logic [W-1:0] data_next,
    output logic         full
);

    localparam int CW = cnt_w(W);

    logic [W-1:0]  data_r;
    logic [CW-1:0] cnt_r;
    logic [W:0]    shifted_s;

    assign shifted_s = {data_r, din};
    assign data_next = shifted_s[W-1:0];
    assign full      = en && (cnt_r == CW'(W - 1));
    assign data      = data_r;

    // Shift register and bit counter; counter wraps to 0 once the field is complete.
    always_ff @(posedge clkEn or posedge rst) begin
        if (rst) begin
            data_r <= '0;
            cnt_r  <= '0;
        end else if (clr) begin
            data_r <= '0;
            cnt_r  <= '0;
        end else if (en) begin
            data_r <= data_next;
            cnt_r  <= full ? '0 : cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/serial_demux_rx.sv
// Serial frame receiver: start bit, channel address, length, data routed to
// one of 2**ADDR_W channels, optional even-parity bit.
module serial_demux_rx
    import serial_demux_rx_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int LEN_W  = 4,
    parameter bit PARITY = 1'b1
) (
    input  logic                          clkEn,
    input  logic                          rst,
    input  logic                          serIn,
    input  logic [nch_of(ADDR_W)-1:0]     chanMask,
    output logic [nch_of(ADDR_W)-1:0]     serOut,
    output logic [nch_of(ADDR_W)-1:0]     serOutValid,
    output logic [ADDR_W-1:0]             addr,
    output logic                          done,
    output logic                          parityErr,
    output logic                          dropped
);

    localparam int NCH = nch_of(ADDR_W);

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W-1:0]   addr_r;
    logic                en_r;
    logic [LEN_W-1:0]    cnt_r;
    logic                par_r;
    logic                parity_err_r;
    logic                dropped_r;

    logic                start_s;
    logic [ADDR_W-1:0]   addr_field_s;
    logic [ADDR_W-1:0]   addr_next_s;
    logic                addr_full_s;
    logic [LEN_W-1:0]    len_field_s;
    logic [LEN_W-1:0]    len_next_s;
    logic                len_full_s;

    assign start_s = (state_r == IDLE) && (serIn == 1'b0);

    serial_field_shifter #(.W(ADDR_W)) u_addr_shift (
        .clkEn     (clkEn),
        .rst       (rst),
        .en        (state_r == ADDR),
        .clr       (start_s),
        .din       (serIn),
        .data      (addr_field_s),
        .data_next (addr_next_s),
        .full      (addr_full_s)
    );

    serial_field_shifter #(.W(LEN_W)) u_len_shift (
        .clkEn     (clkEn),
        .rst       (rst),
        .en        (state_r == LEN),
        .clr       (start_s),
        .din       (serIn),
        .data      (len_field_s),
        .data_next (len_next_s),
        .full      (len_full_s)
    );

    // Next-state decode; unknown encodings fall back to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (serIn == 1'b0) state_next_s = ADDR;
                else               state_next_s = IDLE;
            end
            ADDR: begin
                if (addr_full_s) state_next_s = LEN;
                else             state_next_s = ADDR;
            end
            LEN: begin
                if (len_full_s) begin
                    if (len_next_s == '0) state_next_s = IDLE;
                    else                  state_next_s = DATA;
                end else begin
                    state_next_s = LEN;
                end
            end
            DATA: begin
                if (cnt_r == LEN_W'(1)) state_next_s = PARITY ? PAR : IDLE;
                else                    state_next_s = DATA;
            end
            PAR:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register plus per-frame address, enable, length counter and status flags.
    always_ff @(posedge clkEn or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            addr_r       <= '0;
            en_r         <= 1'b0;
            cnt_r        <= '0;
            par_r        <= 1'b0;
            parity_err_r <= 1'b0;
            dropped_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                IDLE: begin
                    if (serIn == 1'b0) begin
                        par_r        <= 1'b0;
                        parity_err_r <= 1'b0;
                        dropped_r    <= 1'b0;
                    end
                end
                ADDR: begin
                    if (addr_full_s) begin
                        addr_r    <= addr_next_s;
                        en_r      <= chanMask[addr_next_s];
                        dropped_r <= ~chanMask[addr_next_s];
                    end
                end
                LEN: begin
                    if (len_full_s) begin
                        cnt_r <= len_next_s;
                    end
                end
                DATA: begin
                    par_r <= par_r ^ serIn;
                    cnt_r <= cnt_r - LEN_W'(1);
                end
                PAR: begin
                    parity_err_r <= par_r ^ serIn;
                end
                default: begin
                end
            endcase
        end
    end

    // Data routing is combinational so the addressed consumer sees serIn in the same cycle.
    always_comb begin
        serOut      = '0;
        serOutValid = '0;
        if (state_r == DATA) begin
            serOut      = {{(NCH-1){1'b0}}, serIn} << addr_r;
            serOutValid = {{(NCH-1){1'b0}}, en_r} << addr_r;
        end else begin
            serOut      = '0;
            serOutValid = '0;
        end
    end

    assign addr      = addr_r;
    assign done      = (state_r == IDLE);
    assign parityErr = parity_err_r;
    assign dropped   = dropped_r;

endmodule

// File: tb/tb_serial_demux_rx.sv
// Directed self-checking bench for serial_demux_rx (ADDR_W=2, LEN_W=4, PARITY=1).
module tb_serial_demux_rx;

    logic       clkEn = 1'b0;
    logic       rst;
    logic       serIn;
    logic [3:0] chanMask;
    logic [3:0] serOut;
    logic [3:0] serOutValid;
    logic [1:0] addr;
    logic       done;
    logic       parityErr;
    logic       dropped;

    int n_checks = 0;
    int n_err    = 0;

    int          v_cnt;
    logic [3:0]  valid_or;
    logic [31:0] d_bits;
    logic [31:0] done_v;

    serial_demux_rx #(.ADDR_W(2), .LEN_W(4), .PARITY(1'b1)) dut (
        .clkEn       (clkEn),
        .rst         (rst),
        .serIn       (serIn),
        .chanMask    (chanMask),
        .serOut      (serOut),
        .serOutValid (serOutValid),
        .addr        (addr),
        .done        (done),
        .parityErr   (parityErr),
        .dropped     (dropped)
    );

    always #5 clkEn = ~clkEn;

    task automatic drive_bit(input logic b);
        @(negedge clkEn);
        serIn = b;
        #1;
    endtask

    // Sends n bits (bits[n-1] first), records per-bit observations, then idles one bit.
    task automatic send_bits(input logic [31:0] bits, input int n);
        v_cnt    = 0;
        valid_or = 4'b0000;
        d_bits   = 32'd0;
        done_v   = 32'd0;
        for (int i = 0; i < n; i++) begin
            drive_bit(bits[n-1-i]);
            done_v[i] = done;
            if (serOutValid != 4'b0000) begin
                v_cnt++;
                valid_or = valid_or | serOutValid;
                d_bits   = {d_bits[30:0], |(serOut & serOutValid)};
            end
        end
        drive_bit(1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; serIn = 1'b1; chanMask = 4'b1111;
        #2;
        n_checks++; if (serOut !== 4'b0000) begin n_err++; $display("FAIL reset_serOut: got %b expected 0000", serOut); end
        n_checks++; if (serOutValid !== 4'b0000) begin n_err++; $display("FAIL reset_valid: got %b expected 0000", serOutValid); end
        n_checks++; if (addr !== 2'd0) begin n_err++; $display("FAIL reset_addr: got %0d expected 0", addr); end
        n_checks++; if (parityErr !== 1'b0) begin n_err++; $display("FAIL reset_parityErr: got %b expected 0", parityErr); end
        n_checks++; if (dropped !== 1'b0) begin n_err++; $display("FAIL reset_dropped: got %b expected 0", dropped); end
        n_checks++; if (done !== 1'b1) begin n_err++; $display("FAIL reset_done: got %b expected 1", done); end
        @(negedge clkEn);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_bit(1'b1);
            n_checks++; if (done !== 1'b1) begin n_err++; $display("FAIL idle_done[%0d]: got %b expected 1", i, done); end
        end
    endtask

    task automatic test_normal();
        chanMask = 4'b1111;
        send_bits(32'b01000111010, 11);
        n_checks++; if (v_cnt !== 3) begin n_err++; $display("FAIL normal_vcnt: got %0d expected 3", v_cnt); end
        n_checks++; if (valid_or !== 4'b0100) begin n_err++; $display("FAIL normal_valid: got %b expected 0100", valid_or); end
        n_checks++; if (d_bits[2:0] !== 3'b101) begin n_err++; $display("FAIL normal_data: got %b expected 101", d_bits[2:0]); end
        n_checks++; if (done_v[10] !== 1'b0) begin n_err++; $display("FAIL normal_done_par: got %b expected 0", done_v[10]); end
        n_checks++; if (done !== 1'b1) begin n_err++; $display("FAIL normal_done: got %b expected 1", done); end
        n_checks++; if (addr !== 2'd2) begin n_err++; $display("FAIL normal_addr: got %0d expected 2", addr); end
        n_checks++; if (parityErr !== 1'b0) begin n_err++; $display("FAIL normal_parityErr: got %b expected 0", parityErr); end
        n_checks++; if (dropped !== 1'b0) begin n_err++; $display("FAIL normal_dropped: got %b expected 0", dropped); end
    endtask

    task automatic test_parity_error();
        chanMask = 4'b1111;
        send_bits(32'b01100111101, 11);
        n_checks++; if (v_cnt !== 3) begin n_err++; $display("FAIL perr_vcnt: got %0d expected 3", v_cnt); end
        n_checks++; if (valid_or !== 4'b1000) begin n_err++; $display("FAIL perr_valid: got %b expected 1000", valid_or); end
        n_checks++; if (d_bits[2:0] !== 3'b110) begin n_err++; $display("FAIL perr_data: got %b expected 110", d_bits[2:0]); end
        n_checks++; if (parityErr !== 1'b1) begin n_err++; $display("FAIL perr_flag: got %b expected 1", parityErr); end
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        n_checks++; if (parityErr !== 1'b1) begin n_err++; $display("FAIL perr_hold: got %b expected 1", parityErr); end
    endtask

    task automatic test_zero_length();
        send_bits(32'b0010000, 7);
        n_checks++; if (v_cnt !== 0) begin n_err++; $display("FAIL zero_vcnt: got %0d expected 0", v_cnt); end
        n_checks++; if (done_v[6] !== 1'b0) begin n_err++; $display("FAIL zero_done_len: got %b expected 0", done_v[6]); end
        n_checks++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b expected 1", done); end
        n_checks++; if (addr !== 2'd1) begin n_err++; $display("FAIL zero_addr: got %0d expected 1", addr); end
        n_checks++; if (parityErr !== 1'b0) begin n_err++; $display("FAIL zero_parityErr: got %b expected 0", parityErr); end
    endtask

    task automatic test_masked();
        chanMask = 4'b1011;
        send_bits(32'b01000111010, 11);
        n_checks++; if (v_cnt !== 0) begin n_err++; $display("FAIL mask_vcnt: got %0d expected 0", v_cnt); end
        n_checks++; if (dropped !== 1'b1) begin n_err++; $display("FAIL mask_dropped: got %b expected 1", dropped); end
        n_checks++; if (done_v[10] !== 1'b0) begin n_err++; $display("FAIL mask_done_par: got %b expected 0", done_v[10]); end
        n_checks++; if (done !== 1'b1) begin n_err++; $display("FAIL mask_done: got %b expected 1", done); end
        n_checks++; if (addr !== 2'd2) begin n_err++; $display("FAIL mask_addr: got %0d expected 2", addr); end
    endtask

    task automatic test_back_to_back();
        chanMask = 4'b1111;
        send_bits({10'd0, 11'b01000111010, 11'b01100111101}, 22);
        n_checks++; if (v_cnt !== 6) begin n_err++; $display("FAIL b2b_vcnt: got %0d expected 6", v_cnt); end
        n_checks++; if (d_bits[5:0] !== 6'b101110) begin n_err++; $display("FAIL b2b_data: got %b expected 101110", d_bits[5:0]); end
        n_checks++; if (done_v[12:10] !== 3'b010) begin n_err++; $display("FAIL b2b_done_gap: got %b expected 010", done_v[12:10]); end
        n_checks++; if (addr !== 2'd3) begin n_err++; $display("FAIL b2b_addr: got %0d expected 3", addr); end
        n_checks++; if (parityErr !== 1'b1) begin n_err++; $display("FAIL b2b_parityErr: got %b expected 1", parityErr); end
        n_checks++; if (dropped !== 1'b0) begin n_err++; $display("FAIL b2b_dropped: got %b expected 0", dropped); end
    endtask

    task automatic test_reset_mid_data();
        logic [6:0] hdr;
        chanMask = 4'b1111;
        hdr = 7'b0100011;
        for (int i = 6; i >= 0; i--) drive_bit(hdr[i]);
        drive_bit(1'b1);
        n_checks++; if (serOutValid !== 4'b0100) begin n_err++; $display("FAIL mid_valid_d0: got %b expected 0100", serOutValid); end
        drive_bit(1'b0);
        rst = 1'b1;
        #1;
        n_checks++; if (serOutValid !== 4'b0000) begin n_err++; $display("FAIL mid_rst_valid: got %b expected 0000", serOutValid); end
        n_checks++; if (done !== 1'b1) begin n_err++; $display("FAIL mid_rst_done: got %b expected 1", done); end
        n_checks++; if (addr !== 2'd0) begin n_err++; $display("FAIL mid_rst_addr: got %0d expected 0", addr); end
        serIn = 1'b1;
        #1;
        rst = 1'b0;
        send_bits(32'b01000111010, 11);
        n_checks++; if (v_cnt !== 3) begin n_err++; $display("FAIL mid_after_vcnt: got %0d expected 3", v_cnt); end
        n_checks++; if (d_bits[2:0] !== 3'b101) begin n_err++; $display("FAIL mid_after_data: got %b expected 101", d_bits[2:0]); end
        n_checks++; if (addr !== 2'd2) begin n_err++; $display("FAIL mid_after_addr: got %0d expected 2", addr); end
        n_checks++; if (parityErr !== 1'b0) begin n_err++; $display("FAIL mid_after_parityErr: got %b expected 0", parityErr); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_parity_error();
        test_zero_length();
        test_masked();
        test_back_to_back();
        test_reset_mid_data();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
